// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and operand-sign helpers
// for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } state_t;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV)  || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) ||
           (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference if non-negative.
module muldiv_div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem_in,
  input  logic [N-1:0] quo_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic [N-1:0] quo_out
);

  logic [N:0] shifted;
  logic [N:0] trial;

  assign shifted = {rem_in, quo_in[N-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign rem_out = trial[N] ? shifted[N-1:0]
                            : trial[N-1:0];
  assign quo_out = {quo_in[N-2:0], ~trial[N]};

endmodule

// File: rtl/seq_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one iteration per cycle.
// MULDIV_EARLY_OUT_EN: trivial operands bypass RUN.
module seq_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] res,
  output logic         zf,
  output logic         neg
);

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t           state;
  logic [2:0]       op_r;
  logic [N-1:0]     a_raw;
  logic [N-1:0]     b_raw;
  logic [N-1:0]     m_r;
  logic [2*N-1:0]   acc;
  logic             sa;
  logic             sb;
  logic             div0;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic             fix_ph;

  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic [N-1:0]     a_mag;
  logic [N-1:0]     b_mag;
  logic             ovf_c;
  logic             early;
  logic [N:0]       mul_sum;
  logic [N-1:0]     rem_nx;
  logic [N-1:0]     quo_nx;
  logic [2*N-1:0]   acc_fix;
  logic [N-1:0]     res_nx;

  assign is_div = op_r[2];
  assign a_neg  = is_signed_a(op_r) & a_raw[N-1];
  assign b_neg  = is_signed_b(op_r) & b_raw[N-1];
  assign a_mag  = a_neg ? -a_raw : a_raw;
  assign b_mag  = b_neg ? -b_raw : b_raw;
  assign ovf_c  = is_div && !op_r[0] &&
                  (a_raw == MIN_NEG) && (b_raw == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = is_div ? ((b_raw == '0) || ovf_c)
                        : ((a_raw == '0) || (b_raw == '0));
`else
  assign early = 1'b0;
`endif

  // Shift-add: multiplier sits in acc low half, LSB first
  assign mul_sum = {1'b0, acc[2*N-1:N]} +
                   (acc[0] ? {1'b0, m_r} : '0);

  muldiv_div_step #(.N(N)) u_div_step (
    .rem_in  (acc[2*N-1:N]),
    .quo_in  (acc[N-1:0]),
    .divisor (m_r),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_comb begin
    acc_fix = acc;
    if (!is_div) begin
      if (sa ^ sb) acc_fix = -acc;
    end else begin
      if (sa) acc_fix[2*N-1:N] = -acc[2*N-1:N];
      if (sa ^ sb) acc_fix[N-1:0] = -acc[N-1:0];
    end
  end

  // Divide special cases override the iterated value
  always_comb begin
    res_nx = '0;
    unique case (1'b1)
      !is_div && (op_r == OP_MUL): res_nx = acc[N-1:0];
      !is_div && (op_r != OP_MUL): res_nx = acc[2*N-1:N];
      is_div && !op_r[1]:
        res_nx = div0 ? '1 : ovf ? MIN_NEG : acc[N-1:0];
      is_div && op_r[1]:
        res_nx = div0 ? a_raw : ovf ? '0 : acc[2*N-1:N];
      default: res_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= '0;
      a_raw  <= '0;
      b_raw  <= '0;
      m_r    <= '0;
      acc    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      fix_ph <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op;
            a_raw <= rs1;
            b_raw <= rs2;
            busy  <= 1'b1;
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          sa     <= a_neg;
          sb     <= b_neg;
          div0   <= (b_raw == '0);
          ovf    <= ovf_c;
          cnt    <= CNT_W'(N);
          fix_ph <= 1'b0;
          if (is_div) begin
            acc <= {{N{1'b0}}, a_mag};
            m_r <= b_mag;
          end else begin
            acc <= early ? '0 : {{N{1'b0}}, b_mag};
            m_r <= a_mag;
          end
          state <= early ? FIX : RUN;
        end
        RUN: begin
          acc <= is_div ? {rem_nx, quo_nx}
                        : {mul_sum, acc[N-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          // Sign fix-up first, result select next cycle
          if (!fix_ph) begin
            acc    <= acc_fix;
            fix_ph <= 1'b1;
          end else begin
            res   <= res_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zf  = (res == '0);
  assign neg = res[N-1];

endmodule
